// File: rtl/mips_pkg.sv
// Shared MIPS register-file definitions used by the core and its benches.
package mips_pkg;

  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  // r0 is hardwired to zero in the MIPS ISA
  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : mips_pkg

// File: rtl/reg_cell.sv
// One architectural register: a DATA_W-wide flop with synchronous
// active-high clear and a load enable driven by the one-hot write decode.
module reg_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Clear has priority over load, so a write coinciding with reset is lost.
  // NOTE: state is updated with <= so every cell samples the pre-edge value.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : reg_cell

// File: rtl/regfile_2r1w.sv
// MIPS general-purpose register file: 2 combinational read ports, 1 write port.
// r0 has no storage and always reads zero. With BYPASS=1, a write happening
// this cycle is forwarded to any read port addressing the same register.
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_write_en,
  input  logic [ADDR_W-1:0] ctrl_write_reg,
  input  logic [ADDR_W-1:0] ctrl_read_reg_a,
  input  logic [ADDR_W-1:0] ctrl_read_reg_b,
  input  logic [DATA_W-1:0] data_write,
  output logic [DATA_W-1:0] data_read_a,
  output logic [DATA_W-1:0] data_read_b
);

  import mips_pkg::*;

  localparam int                NUM_REGS  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  // Register contents; entry 0 is a constant, not a flop.
  logic [DATA_W-1:0] regs [NUM_REGS];

  // One-hot write select; bit 0 does not exist because r0 is never written.
  logic [NUM_REGS-1:1] wsel;

  // One-hot read selects and the AND-OR mux results before bypass.
  logic [NUM_REGS-1:0] rsel_a;
  logic [NUM_REGS-1:0] rsel_b;
  logic [DATA_W-1:0]   mux_a;
  logic [DATA_W-1:0]   mux_b;

  // Bypass qualifiers.
  logic fwd_ok;
  logic fwd_a;
  logic fwd_b;

  assign regs[0] = '0;

  // Storage for r1..r(NUM_REGS-1), each enabled by its decoded write select.
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    assign wsel[i] = ctrl_write_en && (ctrl_write_reg == ADDR_W'(i));

    reg_cell #(
      .DATA_W (DATA_W)
    ) u_cell (
      .clock (clock),
      .reset (reset),
      .en    (wsel[i]),
      .d     (data_write),
      .q     (regs[i])
    );
  end

  // Decode each read address to one-hot and OR together the selected words.
  // NOTE: every variable gets a default at the top so no latch is inferred.
  always_comb begin
    rsel_a = '0;
    rsel_b = '0;
    mux_a  = '0;
    mux_b  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rsel_a[i] = (ctrl_read_reg_a == ADDR_W'(i));
      rsel_b[i] = (ctrl_read_reg_b == ADDR_W'(i));
      mux_a     = mux_a | (regs[i] & {DATA_W{rsel_a[i]}});
      mux_b     = mux_b | (regs[i] & {DATA_W{rsel_b[i]}});
    end
  end

  // Forwarding is only legal for a real write to a non-zero register that
  // reset is not about to discard.
  assign fwd_ok = (BYPASS != 0) && ctrl_write_en && !reset
                  && (ctrl_write_reg != ZERO_ADDR);
  assign fwd_a  = fwd_ok && (ctrl_write_reg == ctrl_read_reg_a);
  assign fwd_b  = fwd_ok && (ctrl_write_reg == ctrl_read_reg_b);

  assign data_read_a = fwd_a ? data_write : mux_a;
  assign data_read_b = fwd_b ? data_write : mux_b;

  // A write with an unknown destination would corrupt an arbitrary register.
  a_write_addr_known : assert property (
    @(posedge clock) ctrl_write_en |-> !$isunknown(ctrl_write_reg)
  );

endmodule : regfile_2r1w

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: a bypassing and a non-bypassing instance share the
// same stimulus and are compared against a behavioural register-array model.
module tb_regfile_2r1w;

  import mips_pkg::*;

  logic      clock;
  logic      reset;
  logic      ctrl_write_en;
  reg_addr_t ctrl_write_reg;
  reg_addr_t ctrl_read_reg_a;
  reg_addr_t ctrl_read_reg_b;
  word_t     data_write;
  word_t     rd_a_byp, rd_b_byp;
  word_t     rd_a_nb, rd_b_nb;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural state as seen by the program.
  word_t model [REG_COUNT];

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
    .clock           (clock),
    .reset           (reset),
    .ctrl_write_en   (ctrl_write_en),
    .ctrl_write_reg  (ctrl_write_reg),
    .ctrl_read_reg_a (ctrl_read_reg_a),
    .ctrl_read_reg_b (ctrl_read_reg_b),
    .data_write      (data_write),
    .data_read_a     (rd_a_byp),
    .data_read_b     (rd_b_byp)
  );

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
    .clock           (clock),
    .reset           (reset),
    .ctrl_write_en   (ctrl_write_en),
    .ctrl_write_reg  (ctrl_write_reg),
    .ctrl_read_reg_a (ctrl_read_reg_a),
    .ctrl_read_reg_b (ctrl_read_reg_b),
    .data_write      (data_write),
    .data_read_a     (rd_a_nb),
    .data_read_b     (rd_b_nb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input word_t actual, input word_t expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input reg_addr_t wr,
                       input word_t wd, input reg_addr_t ra, input reg_addr_t rb);
    reset           = rst;
    ctrl_write_en   = we;
    ctrl_write_reg  = wr;
    data_write      = wd;
    ctrl_read_reg_a = ra;
    ctrl_read_reg_b = rb;
  endtask

  // Expected read value from the architectural rules, given current inputs.
  function automatic word_t model_read(input reg_addr_t addr, input bit bypass);
    if (bypass && ctrl_write_en && !reset && ctrl_write_reg == addr && addr != 0)
      return data_write;
    if (addr == 0)
      return '0;
    return model[addr];
  endfunction

  // Advance one clock and apply the same edge to the model.
  task automatic cycle_end();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) model[i] = '0;
    end else if (ctrl_write_en && ctrl_write_reg != 0) begin
      model[ctrl_write_reg] = data_write;
    end
    #1;
  endtask

  typedef struct {
    logic      rst;
    logic      we;
    reg_addr_t wr;
    word_t     wd;
    reg_addr_t ra;
    reg_addr_t rb;
    word_t     exp_a_byp;
    word_t     exp_b_byp;
    word_t     exp_a_nb;
    word_t     exp_b_nb;
  } vec_t;

  vec_t vecs [13];

  task automatic apply_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].ra, vecs[i].rb);
      @(negedge clock);
      check($sformatf("vec%0d_a_byp", i), rd_a_byp, vecs[i].exp_a_byp);
      check($sformatf("vec%0d_b_byp", i), rd_b_byp, vecs[i].exp_b_byp);
      check($sformatf("vec%0d_a_nb", i),  rd_a_nb,  vecs[i].exp_a_nb);
      check($sformatf("vec%0d_b_nb", i),  rd_b_nb,  vecs[i].exp_b_nb);
      cycle_end();
    end
  endtask

  // Read every register on both ports of both instances with no write active.
  task automatic scan_all(input string tag, input word_t exp [REG_COUNT]);
    for (int i = 0; i < REG_COUNT; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, reg_addr_t'(i), reg_addr_t'(REG_COUNT - 1 - i));
      @(negedge clock);
      check($sformatf("%s_a_r%0d", tag, i),       rd_a_byp, exp[i]);
      check($sformatf("%s_b_r%0d", tag, 31 - i),  rd_b_byp, exp[31 - i]);
      check($sformatf("%s_nb_a_r%0d", tag, i),    rd_a_nb,  exp[i]);
      check($sformatf("%s_nb_b_r%0d", tag, 31 - i), rd_b_nb, exp[31 - i]);
      cycle_end();
    end
  endtask

  initial begin
    word_t exp_regs [REG_COUNT];

    //             rst  we  wr     wd            ra     rb     a_byp         b_byp         a_nb          b_nb
    vecs[0]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b1, 5'd31, 32'h12345678, 5'd5,  5'd31, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678};
    vecs[3]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[4]  = '{1'b0, 1'b1, 5'd7,  32'h11111111, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[5]  = '{1'b0, 1'b1, 5'd7,  32'h22222222, 5'd7,  5'd7,  32'h22222222, 32'h22222222, 32'h11111111, 32'h11111111};
    vecs[6]  = '{1'b0, 1'b1, 5'd9,  32'hAAAA5555, 5'd7,  5'd7,  32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222};
    vecs[7]  = '{1'b1, 1'b1, 5'd9,  32'h0F0F0F0F, 5'd9,  5'd5,  32'hAAAA5555, 32'hDEADBEEF, 32'hAAAA5555, 32'hDEADBEEF};
    vecs[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd9,  5'd5,  32'h0,        32'h0,        32'h0,        32'h0};
    vecs[9]  = '{1'b0, 1'b1, 5'd3,  32'h1,        5'd3,  5'd0,  32'h1,        32'h0,        32'h0,        32'h0};
    vecs[10] = '{1'b0, 1'b1, 5'd3,  32'h2,        5'd3,  5'd4,  32'h2,        32'h0,        32'h1,        32'h0};
    vecs[11] = '{1'b0, 1'b1, 5'd4,  32'h3,        5'd3,  5'd4,  32'h2,        32'h3,        32'h2,        32'h0};
    vecs[12] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd3,  5'd4,  32'h2,        32'h3,        32'h2,        32'h3};

    // Power-up reset; contents are unknown before this edge.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < REG_COUNT; i++) model[i] = '0;
    cycle_end();

    for (int i = 0; i < REG_COUNT; i++) exp_regs[i] = '0;
    scan_all("rst", exp_regs);

    // Writes to r5/r31, then an r0 write that must change nothing.
    apply_vecs(0, 3);
    exp_regs[5]  = 32'hDEADBEEF;
    exp_regs[31] = 32'h12345678;
    scan_all("r0prot", exp_regs);

    // Same-cycle forwarding, reset beating a write, back-to-back writes.
    apply_vecs(4, 12);
    for (int i = 0; i < REG_COUNT; i++) exp_regs[i] = '0;
    exp_regs[3] = 32'h2;
    exp_regs[4] = 32'h3;
    scan_all("b2b", exp_regs);

    // Randomized traffic against the model on both ports of both instances.
    for (int c = 0; c < 1000; c++) begin
      logic      rst;
      logic      we;
      reg_addr_t wr, ra, rb;
      rst = ($urandom_range(0, 49) == 0);
      we  = ($urandom_range(0, 3) != 0);
      wr  = reg_addr_t'($urandom_range(0, 31));
      ra  = ($urandom_range(0, 3) == 0) ? wr : reg_addr_t'($urandom_range(0, 31));
      rb  = ($urandom_range(0, 3) == 0) ? wr : reg_addr_t'($urandom_range(0, 31));
      drive(rst, we, wr, word_t'($urandom), ra, rb);
      @(negedge clock);
      check($sformatf("rnd%0d_a_byp", c), rd_a_byp, model_read(ra, 1'b1));
      check($sformatf("rnd%0d_b_byp", c), rd_b_byp, model_read(rb, 1'b1));
      check($sformatf("rnd%0d_a_nb", c),  rd_a_nb,  model_read(ra, 1'b0));
      check($sformatf("rnd%0d_b_nb", c),  rd_b_nb,  model_read(rb, 1'b0));
      cycle_end();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_regfile_2r1w
